// File: rtl/isa_loader_mc.sv
`timescale 1ns/1ps
// isa_loader_mc: host entries cross from clk_i into clk_cpu through a gray-pointer async FIFO,
// then each entry is split into LANES words written to consecutive instruction-RAM addresses.
module isa_loader_mc #(
    parameter int unsigned IN_W       = 64,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LANE_ORDER = 1
) (
    input  logic              clk_cpu,
    input  logic              rstn,
    input  logic              clk_i,
    input  logic [IN_W-1:0]   isa_data_i,
    input  logic [31:0]       isa_addr_i,
    input  logic              isa_wren_i,
    output logic              isa_full_o,
    output logic              isa_ovf_o,
    input  logic              clr_ovf_i,
    input  logic              ram_busy_i,
    output logic [OUT_W-1:0]  isa_data_o,
    output logic [ADDR_W-1:0] isa_addr_o,
    output logic              isa_wren_o,
    output logic              idle_o,
    output logic [31:0]       load_cnt_o
);
    localparam int unsigned LANES = IN_W / OUT_W;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned ENT_W = IN_W + ADDR_W;

    // Reset: asynchronous assertion, deassertion synchronised per domain
    logic [1:0] rst_cpu_q;
    logic [1:0] rst_host_q;
    logic       rst_cpu_n;
    logic       rst_host_n;

    always_ff @(posedge clk_cpu or negedge rstn) begin
        if (!rstn) rst_cpu_q <= 2'b00;
        else       rst_cpu_q <= {rst_cpu_q[0], 1'b1};
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) rst_host_q <= 2'b00;
        else       rst_host_q <= {rst_host_q[0], 1'b1};
    end

    assign rst_cpu_n  = rst_cpu_q[1];
    assign rst_host_n = rst_host_q[1];

    // Host (write) side
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wbin_q, wgray_q, wbin_d;
    logic [PW-1:0]    rgray_s1_q, rgray_s2_q;
    logic [PW-1:0]    rbin_q, rgray_q, rbin_d;
    logic             ovf_q;
    logic             push;

    assign isa_full_o = (wgray_q == {~rgray_s2_q[PW-1 -: 2], rgray_s2_q[PW-3:0]});
    assign push       = isa_wren_i && !isa_full_o;
    assign wbin_d     = wbin_q + PW'(1);
    assign isa_ovf_o  = ovf_q;

    always_ff @(posedge clk_i or negedge rst_host_n) begin
        if (!rst_host_n) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
            if (push) begin
                wbin_q  <= wbin_d;
                wgray_q <= wbin_d ^ (wbin_d >> 1);
            end
            // Overflow wins over a simultaneous clear
            if (isa_wren_i && isa_full_o) ovf_q <= 1'b1;
            else if (clr_ovf_i)           ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wbin_q[AW-1:0]] <= {isa_data_i, isa_addr_i[ADDR_W-1:0]};
    end

    // CPU (read) side
    logic [PW-1:0]    wgray_s1_q, wgray_s2_q;
    logic [ENT_W-1:0] head;
    logic             empty;
    logic             pop;

    assign head   = mem_q[rbin_q[AW-1:0]];
    assign empty  = (rgray_q == wgray_s2_q);
    assign rbin_d = pop ? rbin_q + PW'(1) : rbin_q;

    typedef enum logic [1:0] {StIdle, StWait, StEmit} state_e;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   hold_data_q, hold_data_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [LW-1:0]     lane_idx_q, lane_idx_d;
    logic [LW-1:0]     lane_sel;
    logic [OUT_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0]  lanes [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lanes
        assign lanes[k] = hold_data_q[k*OUT_W +: OUT_W];
    end

    assign lane_sel = (LANE_ORDER != 0) ? LW'(LANES - 1) - lane_idx_q : lane_idx_q;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_addr_d = hold_addr_q;
        lane_idx_d  = lane_idx_q;
        data_d      = data_q;
        addr_d      = addr_q;
        wren_d      = 1'b0;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: state_d = StWait;
            StWait: begin
                if (!empty) begin
                    pop         = 1'b1;
                    hold_data_d = head[ENT_W-1:ADDR_W];
                    hold_addr_d = head[ADDR_W-1:0];
                    lane_idx_d  = '0;
                    state_d     = StEmit;
                end
            end
            StEmit: begin
                if (!ram_busy_i) begin
                    data_d     = lanes[lane_sel];
                    addr_d     = hold_addr_q + ADDR_W'(lane_idx_q);
                    wren_d     = 1'b1;
                    cnt_d      = cnt_q + 32'd1;
                    lane_idx_d = lane_idx_q + LW'(1);
                    if (lane_idx_q == LW'(LANES - 1)) state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge rst_cpu_n) begin
        if (!rst_cpu_n) begin
            wgray_s1_q  <= '0;
            wgray_s2_q  <= '0;
            rbin_q      <= '0;
            rgray_q     <= '0;
            state_q     <= StIdle;
            hold_data_q <= '0;
            hold_addr_q <= '0;
            lane_idx_q  <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            wren_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wgray_s1_q  <= wgray_q;
            wgray_s2_q  <= wgray_s1_q;
            rbin_q      <= rbin_d;
            rgray_q     <= rbin_d ^ (rbin_d >> 1);
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_addr_q <= hold_addr_d;
            lane_idx_q  <= lane_idx_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            wren_q      <= wren_d;
            cnt_q       <= cnt_d;
        end
    end

    assign isa_data_o = data_q;
    assign isa_addr_o = addr_q;
    assign isa_wren_o = wren_q;
    assign load_cnt_o = cnt_q;
    assign idle_o     = (state_q == StWait) && empty;

endmodule

// File: tb/tb_isa_loader_mc.sv
`timescale 1ns/1ps
// Directed and randomised bench for isa_loader_mc (LANE_ORDER=1, 2 lanes of 32 bits, 16-bit addr).
module tb_isa_loader_mc;
    logic        clk_cpu = 1'b0;
    logic        clk_i = 1'b0;
    logic        rstn = 1'b1;
    logic [63:0] isa_data_i = '0;
    logic [31:0] isa_addr_i = '0;
    logic        isa_wren_i = 1'b0;
    logic        clr_ovf_i = 1'b0;
    logic        busy_man = 1'b0;
    logic        busy_rand = 1'b0;
    logic        busy_rnd = 1'b0;
    logic        ram_busy_i;
    logic        isa_full_o, isa_ovf_o, isa_wren_o, idle_o;
    logic [31:0] isa_data_o;
    logic [15:0] isa_addr_o;
    logic [31:0] load_cnt_o;

    assign ram_busy_i = busy_man | (busy_rand & busy_rnd);

    isa_loader_mc dut (
        .clk_cpu    (clk_cpu),
        .rstn       (rstn),
        .clk_i      (clk_i),
        .isa_data_i (isa_data_i),
        .isa_addr_i (isa_addr_i),
        .isa_wren_i (isa_wren_i),
        .isa_full_o (isa_full_o),
        .isa_ovf_o  (isa_ovf_o),
        .clr_ovf_i  (clr_ovf_i),
        .ram_busy_i (ram_busy_i),
        .isa_data_o (isa_data_o),
        .isa_addr_o (isa_addr_o),
        .isa_wren_o (isa_wren_o),
        .idle_o     (idle_o),
        .load_cnt_o (load_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always #13.5 clk_cpu = ~clk_cpu;

    int          cyc = 0;
    logic [15:0] log_addr [$];
    logic [31:0] log_data [$];
    int          log_cyc [$];
    logic [15:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk_cpu) cyc++;

    always @(negedge clk_cpu) begin
        busy_rnd = ($urandom_range(0, 2) == 0);
        if (isa_wren_o) begin
            log_addr.push_back(isa_addr_o);
            log_data.push_back(isa_data_o);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [63:0] d, input logic [31:0] a);
        @(posedge clk_i);
        #1;
        isa_data_i = d;
        isa_addr_i = a;
        isa_wren_i = 1'b1;
        @(posedge clk_i);
        #1;
        isa_wren_i = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    // Wait until n words are logged and the loader is idle, then confirm no extra writes follow
    task automatic wait_drain(input int n, input string tag);
        int k;
        k = 0;
        @(posedge clk_cpu);
        #2;
        while ((log_addr.size() < n || !idle_o) && k < 5000) begin
            @(posedge clk_cpu);
            #2;
            k++;
        end
        repeat (10) @(posedge clk_cpu);
        #2;
        check(tag, 64'(log_addr.size()), 64'(n));
    endtask

    task automatic wait_first_wren(input string tag);
        int k;
        k = 0;
        @(negedge clk_cpu);
        while (!isa_wren_o && k < 200) begin
            @(negedge clk_cpu);
            k++;
        end
        check(tag, 64'(isa_wren_o), 64'd1);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [31:0] a;
        int          errs;

        // Reset state
        #2 rstn = 1'b0;
        repeat (5) @(negedge clk_cpu);
        check("rst_wren", 64'(isa_wren_o), 64'd0);
        check("rst_data", 64'(isa_data_o), 64'd0);
        check("rst_addr", 64'(isa_addr_o), 64'd0);
        check("rst_cnt", 64'(load_cnt_o), 64'd0);
        check("rst_full", 64'(isa_full_o), 64'd0);
        check("rst_ovf", 64'(isa_ovf_o), 64'd0);
        check("rst_idle", 64'(idle_o), 64'd0);
        rstn = 1'b1;
        repeat (6) @(negedge clk_cpu);
        check("idle_after_rst", 64'(idle_o), 64'd1);

        // 1: basic split, MS lane first
        clear_log();
        push(64'h11112222_33334444, 32'h0000_0010);
        wait_drain(2, "t1_count");
        check("t1_a0", 64'(log_addr[0]), 64'h0010);
        check("t1_d0", 64'(log_data[0]), 64'h11112222);
        check("t1_a1", 64'(log_addr[1]), 64'h0011);
        check("t1_d1", 64'(log_data[1]), 64'h33334444);
        check("t1_b2b", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
        check("t1_cnt", 64'(load_cnt_o), 64'd2);
        check("t1_idle", 64'(idle_o), 64'd1);

        // 2: busy for 3 cycles after the first word
        clear_log();
        push(64'h11112222_33334444, 32'h0000_0010);
        wait_first_wren("t2_first");
        busy_man = 1'b1;
        repeat (3) @(negedge clk_cpu);
        busy_man = 1'b0;
        wait_drain(2, "t2_count");
        check("t2_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd4);
        check("t2_a1", 64'(log_addr[1]), 64'h0011);
        check("t2_d1", 64'(log_data[1]), 64'h33334444);
        check("t2_cnt", 64'(load_cnt_o), 64'd4);

        // 3: address wrap
        clear_log();
        push(64'hAAAA0001_BBBB0002, 32'h0000_FFFF);
        wait_drain(2, "t3_count");
        check("t3_a0", 64'(log_addr[0]), 64'hFFFF);
        check("t3_d0", 64'(log_data[0]), 64'hAAAA0001);
        check("t3_a1", 64'(log_addr[1]), 64'h0000);
        check("t3_d1", 64'(log_data[1]), 64'hBBBB0002);
        check("t3_cnt", 64'(load_cnt_o), 64'd6);

        // 4: fill under busy; entry 0 parks in the loader's hold register, 16 more fill the FIFO
        clear_log();
        busy_man = 1'b1;
        push({32'hA000_0000, 32'hB000_0000}, 32'h0000_0100);
        repeat (20) @(negedge clk_cpu);
        for (int i = 1; i <= 18; i++) begin
            push({32'hA000_0000 + i, 32'hB000_0000 + i}, 32'h0000_0100 + 32'(2 * i));
            if (i == 15) check("t4_not_full", 64'(isa_full_o), 64'd0);
            if (i == 16) check("t4_full", 64'(isa_full_o), 64'd1);
        end
        check("t4_ovf", 64'(isa_ovf_o), 64'd1);
        @(posedge clk_i);
        #1 clr_ovf_i = 1'b1;
        @(posedge clk_i);
        #1 clr_ovf_i = 1'b0;
        check("t4_clr", 64'(isa_ovf_o), 64'd0);
        @(posedge clk_i);
        #1;
        clr_ovf_i = 1'b1;
        isa_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
        isa_wren_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_ovf_i = 1'b0;
        isa_wren_i = 1'b0;
        check("t4_clr_vs_ovf", 64'(isa_ovf_o), 64'd1);
        busy_man = 1'b0;
        wait_drain(34, "t4_count");
        for (int j = 0; j <= 16; j++) begin
            check("t4_addr_hi", 64'(log_addr[2 * j]), 64'(16'h0100 + 16'(2 * j)));
            check("t4_data_hi", 64'(log_data[2 * j]), 64'(32'hA000_0000 + 32'(j)));
            check("t4_addr_lo", 64'(log_addr[2 * j + 1]), 64'(16'h0101 + 16'(2 * j)));
            check("t4_data_lo", 64'(log_data[2 * j + 1]), 64'(32'hB000_0000 + 32'(j)));
        end
        check("t4_cnt", 64'(load_cnt_o), 64'd40);
        @(posedge clk_i);
        #1 clr_ovf_i = 1'b1;
        @(posedge clk_i);
        #1 clr_ovf_i = 1'b0;
        check("t4_clr_end", 64'(isa_ovf_o), 64'd0);

        // 5: reset after the first lane of a burst
        clear_log();
        push(64'h55556666_77778888, 32'h0000_0020);
        wait_first_wren("t5_first");
        rstn = 1'b0;
        #1;
        check("t5_wren", 64'(isa_wren_o), 64'd0);
        check("t5_data", 64'(isa_data_o), 64'd0);
        check("t5_addr", 64'(isa_addr_o), 64'd0);
        check("t5_cnt", 64'(load_cnt_o), 64'd0);
        repeat (4) @(negedge clk_cpu);
        rstn = 1'b1;
        repeat (30) @(negedge clk_cpu);
        check("t5_writes", 64'(log_addr.size()), 64'd1);
        check("t5_d0", 64'(log_data[0]), 64'h55556666);
        check("t5_idle", 64'(idle_o), 64'd1);
        check("t5_cnt_after", 64'(load_cnt_o), 64'd0);

        // 6: 1000 random entries with random RAM busy; host honours isa_full_o
        clear_log();
        busy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int k;
            d = {$urandom, $urandom};
            a = $urandom;
            @(posedge clk_i);
            #1;
            k = 0;
            while (isa_full_o && k < 1000) begin
                @(posedge clk_i);
                #1;
                k++;
            end
            isa_data_i = d;
            isa_addr_i = a;
            isa_wren_i = 1'b1;
            exp_addr.push_back(a[15:0]);
            exp_data.push_back(d[63:32]);
            exp_addr.push_back(a[15:0] + 16'd1);
            exp_data.push_back(d[31:0]);
            @(posedge clk_i);
            #1 isa_wren_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
        end
        busy_rand = 1'b0;
        wait_drain(2000, "t6_count");
        errs = 0;
        for (int j = 0; j < 2000 && j < log_addr.size(); j++) begin
            if (log_addr[j] !== exp_addr[j] || log_data[j] !== exp_data[j]) errs++;
        end
        check("t6_words", 64'(errs), 64'd0);
        check("t6_ovf", 64'(isa_ovf_o), 64'd0);
        check("t6_cnt", 64'(load_cnt_o), 64'd2000);
        check("t6_idle", 64'(idle_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
